// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC control sequencer: opcodes, states, instruction
// classes, the control-word layout and the opcode-to-ALU mapping.
package mini_src_ctrl_pkg;

    localparam logic [4:0] ADD_OP = 5'b00100;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_t;

    typedef enum logic [3:0] {
        ClsLd, ClsLdi, ClsSt, ClsAlu, ClsImm, ClsMulDiv, ClsUnary, ClsBr,
        ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
    } class_t;

    typedef struct packed {
        logic       pc_in, ir_in, hi_in, lo_in, zhigh_in, zlow_in, mar_in, mdr_in;
        logic       out_port, y_in;
        logic       pc_out, hi_out, lo_out, zhigh_out, zlow_out, in_port, mdr_out, c_out;
        logic       gra, grb, grc, r_in, r_out, ba_out;
        logic       read, write, inc_pc, con_in, glr;
        logic [4:0] op;
        logic       run;
    } ctrl_t;

    function automatic class_t op_class(input logic [4:0] opc);
        class_t cls;
        if (opc == OpLd)                          cls = ClsLd;
        else if (opc == OpLdi)                    cls = ClsLdi;
        else if (opc == OpSt)                     cls = ClsSt;
        else if (opc >= OpAdd && opc <= OpRol)    cls = ClsAlu;
        else if (opc >= OpAddi && opc <= OpOri)   cls = ClsImm;
        else if (opc == OpMul || opc == OpDiv)    cls = ClsMulDiv;
        else if (opc == OpNeg || opc == OpNot)    cls = ClsUnary;
        else if (opc == OpBr)                     cls = ClsBr;
        else if (opc == OpJr)                     cls = ClsJr;
        else if (opc == OpIn)                     cls = ClsIn;
        else if (opc == OpOut)                    cls = ClsOut;
        else if (opc == OpMfhi)                   cls = ClsMfhi;
        else if (opc == OpMflo)                   cls = ClsMflo;
        else if (opc == OpHalt)                   cls = ClsHalt;
        else                                      cls = ClsNop;  // nop, jal, unused
        return cls;
    endfunction

    // ALU codes sit one above the register-form opcode; immediates reuse add/and/or.
    function automatic logic [4:0] alu_op(input logic [4:0] opc);
        logic [4:0] op;
        if (opc == OpAddi)      op = ADD_OP;
        else if (opc == OpAndi) op = OpAnd + 5'd1;
        else if (opc == OpOri)  op = OpOr + 5'd1;
        else                    op = opc + 5'd1;
        return op;
    endfunction

    function automatic state_t last_step(input class_t cls);
        state_t st;
        case (cls)
            ClsLd, ClsSt:                              st = StT7;
            ClsMulDiv, ClsBr:                          st = StT6;
            ClsLdi, ClsAlu, ClsImm:                    st = StT5;
            ClsUnary:                                  st = StT4;
            ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo:    st = StT3;
            default:                                   st = StT2;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode, branch condition) into the datapath control word.
module ctrl_decode
    import mini_src_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    class_t     cls;
    logic [4:0] alu;

    always_comb begin
        ctrl     = '0;
        cls      = op_class(opcode);
        alu      = alu_op(opcode);
        ctrl.run = !(state inside {StRst, StHalt});
        unique case (state)
            StT0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            StT1: ctrl.inc_pc = 1'b1;
            StT2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            StT3: begin
                case (cls)
                    ClsLd, ClsLdi, ClsSt: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    ClsAlu, ClsImm: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    ClsUnary: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.op = alu; ctrl.zlow_in = 1'b1;
                    end
                    ClsBr: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
                    end
                    ClsJr: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
                    end
                    ClsIn: begin
                        ctrl.in_port = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    ClsOut: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port = 1'b1;
                    end
                    ClsMfhi: begin
                        ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    ClsMflo: begin
                        ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (cls)
                    ClsLd, ClsLdi, ClsSt: begin
                        ctrl.c_out = 1'b1; ctrl.op = ADD_OP;
                        ctrl.zhigh_in = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    ClsAlu: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.op = alu; ctrl.zlow_in = 1'b1;
                    end
                    ClsImm: begin
                        ctrl.c_out = 1'b1; ctrl.op = alu; ctrl.zlow_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.op = alu;
                        ctrl.zhigh_in = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    ClsUnary: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    ClsBr: begin
                        ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (cls)
                    ClsLd, ClsSt: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    ClsLdi, ClsAlu, ClsImm: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    ClsBr: begin
                        ctrl.c_out = 1'b1; ctrl.op = ADD_OP; ctrl.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                case (cls)
                    ClsLd: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    ClsSt: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                    end
                    ClsBr: begin
                        ctrl.zlow_out = con_ff; ctrl.pc_in = con_ff;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                case (cls)
                    ClsLd: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    ClsSt: ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini-SRC: fetch T0-T2, per-class execute T3-T7, halt.
// Holds the state register; the control word comes from ctrl_decode.
module control_unit
    import mini_src_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
    output logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        Read, Write, IncPC, CON_In, GLR,
    output logic [4:0]  OP,
    output logic        Run
);

    state_t     state_q;
    class_t     cls;
    state_t     last;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign cls       = op_class(IR[31:27]);
    assign last      = last_step(cls);
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= StRst;
        end else begin
            case (state_q)
                StRst:  state_q <= StT0;
                StT0:   state_q <= StT1;
                StT1:   state_q <= StT2;
                StT2: begin
                    if (cls == ClsHalt)      state_q <= StHalt;
                    else if (last == StT2)   state_q <= StT0;
                    else                     state_q <= StT3;
                end
                StT3:   state_q <= (last == StT3) ? StT0 : StT4;
                StT4:   state_q <= (last == StT4) ? StT0 : StT5;
                StT5:   state_q <= (last == StT5) ? StT0 : StT6;
                StT6:   state_q <= (last == StT6) ? StT0 : StT7;
                StT7:   state_q <= StT0;
                StHalt: state_q <= StHalt;
                default: state_q <= StRst;
            endcase
        end
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .opcode (IR[31:27]),
        .con_ff (CON_FF),
        .ctrl   (ctrl)
    );

    assign PCin     = ctrl.pc_in;
    assign IRin     = ctrl.ir_in;
    assign HIin     = ctrl.hi_in;
    assign LOin     = ctrl.lo_in;
    assign ZHighin  = ctrl.zhigh_in;
    assign ZLowin   = ctrl.zlow_in;
    assign MARin    = ctrl.mar_in;
    assign MDRin    = ctrl.mdr_in;
    assign OutPort  = ctrl.out_port;
    assign Yin      = ctrl.y_in;
    assign PCout    = ctrl.pc_out;
    assign HIout    = ctrl.hi_out;
    assign LOout    = ctrl.lo_out;
    assign ZHighout = ctrl.zhigh_out;
    assign ZLowout  = ctrl.zlow_out;
    assign InPort   = ctrl.in_port;
    assign MDRout   = ctrl.mdr_out;
    assign Cout     = ctrl.c_out;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign Rin      = ctrl.r_in;
    assign Rout     = ctrl.r_out;
    assign BAout    = ctrl.ba_out;
    assign Read     = ctrl.read;
    assign Write    = ctrl.write;
    assign IncPC    = ctrl.inc_pc;
    assign CON_In   = ctrl.con_in;
    assign GLR      = ctrl.glr;
    assign OP       = ctrl.op;
    assign Run      = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: sequence-table model checked every cycle, plus literal spot checks.
module tb_control_unit;

    logic        Clock, Clear, CON_FF;
    logic [31:0] IR;
    logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
    logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR, Run;
    logic [4:0]  OP;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
        .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin),
        .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .InPort(InPort), .MDRout(MDRout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read), .Write(Write), .IncPC(IncPC),
        .CON_In(CON_In), .GLR(GLR), .OP(OP), .Run(Run)
    );

    localparam logic [29:0] PCIN  = 30'd1 << 0,  IRIN   = 30'd1 << 1,  HIIN  = 30'd1 << 2;
    localparam logic [29:0] LOIN  = 30'd1 << 3,  ZHIN   = 30'd1 << 4,  ZLIN  = 30'd1 << 5;
    localparam logic [29:0] MARIN = 30'd1 << 6,  MDRIN  = 30'd1 << 7,  OUTP  = 30'd1 << 8;
    localparam logic [29:0] YIN   = 30'd1 << 9,  PCOUT  = 30'd1 << 10, HIOUT = 30'd1 << 11;
    localparam logic [29:0] LOOUT = 30'd1 << 12, ZHOUT  = 30'd1 << 13, ZLOUT = 30'd1 << 14;
    localparam logic [29:0] INP   = 30'd1 << 15, MDROUT = 30'd1 << 16, COUT  = 30'd1 << 17;
    localparam logic [29:0] GRA   = 30'd1 << 18, GRB    = 30'd1 << 19, GRC   = 30'd1 << 20;
    localparam logic [29:0] RIN   = 30'd1 << 21, ROUT   = 30'd1 << 22, BAOUT = 30'd1 << 23;
    localparam logic [29:0] READ  = 30'd1 << 24, WRITE  = 30'd1 << 25, INCPC = 30'd1 << 26;
    localparam logic [29:0] CONIN = 30'd1 << 27, GLRB   = 30'd1 << 28, RUN   = 30'd1 << 29;

    logic [29:0] obs;
    assign obs = {Run, GLR, CON_In, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout,
                  MDRout, InPort, ZLowout, ZHighout, LOout, HIout, PCout, Yin, OutPort, MDRin,
                  MARin, ZLowin, ZHighin, LOin, HIin, IRin, PCin};

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [4:0] alu_code(input logic [4:0] opc);
        case (opc)
            5'h03: return 5'h04;  5'h04: return 5'h05;  5'h05: return 5'h06;
            5'h06: return 5'h07;  5'h07: return 5'h08;  5'h08: return 5'h09;
            5'h09: return 5'h0A;  5'h0A: return 5'h0B;  5'h0B: return 5'h0C;
            5'h0C: return 5'h04;  5'h0D: return 5'h06;  5'h0E: return 5'h07;
            5'h0F: return 5'h10;  5'h10: return 5'h11;  5'h11: return 5'h12;
            5'h12: return 5'h13;
            default: return 5'h00;
        endcase
    endfunction

    // Expected word for instruction step s (0 = T0) and execute length n of this opcode.
    function automatic void model_step(input int s, input logic [4:0] opc, input logic con,
                                       output logic [29:0] m, output logic [4:0] op,
                                       output int n);
        logic [29:0] seq [5];
        logic [4:0]  ops [5];
        for (int i = 0; i < 5; i++) begin
            seq[i] = '0;
            ops[i] = '0;
        end
        n = 0;
        if (opc <= 5'h02) begin
            seq[0] = GRB | BAOUT | YIN;
            seq[1] = COUT | ZHIN | ZLIN;
            ops[1] = 5'b00100;
            if (opc == 5'h01) begin
                seq[2] = ZLOUT | GRA | RIN;
                n = 3;
            end else begin
                seq[2] = ZLOUT | MARIN;
                seq[3] = (opc == 5'h00) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
                seq[4] = (opc == 5'h00) ? (MDROUT | GRA | RIN) : WRITE;
                n = 5;
            end
        end else if (opc <= 5'h0E) begin
            seq[0] = GRB | ROUT | YIN;
            seq[1] = ((opc <= 5'h0B) ? (GRC | ROUT) : COUT) | ZLIN;
            ops[1] = alu_code(opc);
            seq[2] = ZLOUT | GRA | RIN;
            n = 3;
        end else if (opc <= 5'h10) begin
            seq[0] = GRA | ROUT | YIN;
            seq[1] = GRB | ROUT | ZHIN | ZLIN;
            ops[1] = alu_code(opc);
            seq[2] = ZLOUT | LOIN;
            seq[3] = ZHOUT | HIIN;
            n = 4;
        end else if (opc <= 5'h12) begin
            seq[0] = GRB | ROUT | ZLIN;
            ops[0] = alu_code(opc);
            seq[1] = ZLOUT | GRA | RIN;
            n = 2;
        end else begin
            case (opc)
                5'h13: begin
                    seq[0] = GRA | ROUT | CONIN;
                    seq[1] = PCOUT | YIN;
                    seq[2] = COUT | ZLIN;
                    ops[2] = 5'b00100;
                    seq[3] = con ? (ZLOUT | PCIN) : '0;
                    n = 4;
                end
                5'h14: begin seq[0] = GRA | ROUT | PCIN;  n = 1; end
                5'h16: begin seq[0] = INP | GRA | RIN;    n = 1; end
                5'h17: begin seq[0] = GRA | ROUT | OUTP;  n = 1; end
                5'h18: begin seq[0] = HIOUT | GRA | RIN;  n = 1; end
                5'h19: begin seq[0] = LOOUT | GRA | RIN;  n = 1; end
                default: n = 0;
            endcase
        end
        m  = '0;
        op = '0;
        if (s == 0)       m = PCOUT | MARIN | READ | MDRIN;
        else if (s == 1)  m = INCPC;
        else if (s == 2)  m = MDROUT | IRIN;
        else if (s - 3 < n) begin
            m  = seq[s - 3];
            op = ops[s - 3];
        end
        m = m | RUN;
    endfunction

    // mstep: -3 before first clear, -1 reset, -2 halted, else step index within instruction.
    int mstep = -3;

    always @(posedge Clock) begin
        logic [29:0] um;
        logic [4:0]  uop;
        int          un;
        if (!Clear) mstep = -1;
        else if (mstep == -1) mstep = 0;
        else if (mstep >= 0) begin
            model_step(mstep, IR[31:27], CON_FF, um, uop, un);
            if (mstep == 2 && IR[31:27] == 5'b11011) mstep = -2;
            else if (mstep + 1 >= 3 + un) mstep = 0;
            else mstep = mstep + 1;
        end
    end

    always @(negedge Clock) begin
        logic [29:0] em;
        logic [4:0]  eop;
        int          en;
        if (mstep != -3) begin
            if (mstep < 0) begin
                em  = '0;
                eop = '0;
            end else begin
                model_step(mstep, IR[31:27], CON_FF, em, eop, en);
            end
            vectors++;
            if (obs !== em || OP !== eop) begin
                miscompares++;
                $display("FAIL model step=%0d ir=%h: got outputs %h op %b, need %h op %b",
                         mstep, IR, obs, OP, em, eop);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, need %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [31:0] cls_ir  [18];
    int          cls_cyc [18];

    initial begin
        cls_ir  = '{32'h00000000, 32'h08000000, 32'h78000000, 32'h80000000, 32'h88000000,
                    32'h90000000, 32'hA0000000, 32'hA8000000, 32'hB0000000, 32'hB8000000,
                    32'hC0000000, 32'hC8000000, 32'hD0000000, 32'h60000000, 32'h70000000,
                    32'h38000000, 32'h58000000, 32'hF8000000};
        cls_cyc = '{8, 6, 7, 7, 5, 5, 4, 3, 4, 4, 4, 4, 3, 6, 6, 6, 6, 3};

        Clear  = 1'b0;
        CON_FF = 1'b0;
        IR     = 32'h12200090;
        tick();
        tick();
        check("rst_outputs", 32'(obs), 32'd0);
        check("rst_op", 32'(OP), 32'd0);

        // st: full fetch + execute
        Clear = 1'b1;
        tick();
        check("st_t0", 32'(obs), 32'(PCOUT | MARIN | READ | MDRIN | RUN));
        repeat (4) tick();
        check("st_t4_op", 32'(OP), 32'h04);
        repeat (3) tick();
        check("st_t7", 32'(obs), 32'(WRITE | RUN));
        tick();
        check("st_next_t0", 32'(PCout), 32'd1);

        // add R1,R2,R3
        IR = 32'h18918000;
        repeat (3) tick();
        check("add_t3", 32'(obs), 32'(GRB | ROUT | YIN | RUN));
        tick();
        check("add_t4", 32'(obs), 32'(GRC | ROUT | ZLIN | RUN));
        check("add_t4_op", 32'(OP), 32'h04);
        tick();
        check("add_t5", 32'(obs), 32'(ZLOUT | GRA | RIN | RUN));
        tick();
        check("add_back_t0", 32'(PCout), 32'd1);

        // branch taken, then not taken
        IR = 32'h98000010;
        CON_FF = 1'b1;
        repeat (6) tick();
        check("br_taken_t6", 32'(obs), 32'(ZLOUT | PCIN | RUN));
        tick();
        CON_FF = 1'b0;
        repeat (6) tick();
        check("br_not_taken_t6", 32'(obs), 32'(RUN));
        tick();
        check("br_back_t0", 32'(PCout), 32'd1);

        // clear during st T6: abort, no Write
        IR = 32'h12200090;
        repeat (6) tick();
        Clear = 1'b0;
        tick();
        check("abort_outputs", 32'(obs), 32'd0);
        Clear = 1'b1;
        tick();
        check("abort_restart_t0", 32'(obs), 32'(PCOUT | MARIN | READ | MDRIN | RUN));

        // halt holds until clear
        IR = 32'hD8000000;
        repeat (3) tick();
        repeat (22) tick();
        check("halt_run", 32'(Run), 32'd0);
        check("halt_outputs", 32'(obs), 32'd0);
        Clear = 1'b0;
        tick();
        IR = 32'hE0000000;
        Clear = 1'b1;
        tick();
        check("halt_restart_t0", 32'(PCout), 32'd1);

        // unused opcode: T2 straight to T0
        repeat (3) tick();
        check("unused_t0", 32'(obs), 32'(PCOUT | MARIN | READ | MDRIN | RUN));

        // remaining classes, each must return to T0 after its hand-counted length
        for (int k = 0; k < 18; k++) begin
            IR = cls_ir[k];
            repeat (cls_cyc[k]) tick();
            check($sformatf("class_%h_back_t0", cls_ir[k][31:27]), 32'(PCout), 32'd1);
        end

        @(negedge Clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini-SRC datapath.
- Drives every datapath control strobe: fetch (T0–T2), decode of IR[31:27], and per-class execute steps (T3–T7); then returns to T0.
- Replaces hand-stepped per-instruction sequencing. Sits beside the datapath; reads IR and CON_Out.

Parameters:
- ADD_OP, 5'b00100, datapath ALU code for add; used for address and branch-target calculation.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  synchronous, active-low reset.
- IR  in  32  instruction register contents.
- CON_FF  in  1  datapath CON_Out (branch condition).
- PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin  out  1 each  register load enables.
- PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout  out  1 each  bus drivers.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and drive.
- Read, Write, IncPC, CON_In, GLR  out  1 each  memory, PC increment, CON latch, GLR.
- OP  out  5  ALU operation.
- Run  out  1  high unless halted or in reset.

Behaviour:
- States, one clock each: RST, T0, T1, T2, T3..T7, HALT.
- Clear low at an edge puts the state in RST.
  - In RST all outputs are 0, OP=0 and Run=0.
  - RST goes to T0 on the first edge with Clear high.
- Outputs are a pure decode of state, IR and CON_FF. Unlisted signals are 0; OP=0 unless stated.
- Fetch:
  - T0: PCout MARin Read MDRin. A read in T0 lands in MDR in the same cycle.
  - T1: IncPC.
  - T2: MDRout IRin.
  - After T2, IR is stable; class is taken from IR[31:27].
- Execute sequences:
  - ld(00000):
    - T3 Grb BAout Yin
    - T4 Cout OP=ADD_OP ZHighin ZLowin
    - T5 ZLowout MARin
    - T6 Read MDRin
    - T7 MDRout Gra Rin
  - ldi(00001): T3–T4 as ld; T5 ZLowout Gra Rin.
  - st(00010):
    - T3–T5 as ld
    - T6 Gra Rout MDRin
    - T7 Write
  - reg ALU (00011–01011: add, sub, and, or, shr, shra, shl, ror, rol):
    - T3 Grb Rout Yin
    - T4 Grc Rout OP ZLowin
    - T5 ZLowout Gra Rin
  - immediate (01100–01110):
    - T3 Grb Rout Yin
    - T4 Cout OP ZLowin
    - T5 ZLowout Gra Rin
  - mul/div (01111, 10000):
    - T3 Gra Rout Yin
    - T4 Grb Rout OP ZHighin ZLowin
    - T5 ZLowout LOin
    - T6 ZHighout HIin
  - neg/not (10001, 10010):
    - T3 Grb Rout OP ZLowin
    - T4 ZLowout Gra Rin
  - branch(10011):
    - T3 Gra Rout CON_In
    - T4 PCout Yin
    - T5 Cout OP=ADD_OP ZLowin
    - T6 ZLowout PCin only if CON_FF=1, else all outputs 0
  - jr(10100): T3 Gra Rout PCin.
  - in(10110): T3 InPort Gra Rin.
  - out(10111): T3 Gra Rout OutPort.
  - mfhi(11000): T3 HIout Gra Rin.
  - mflo(11001): T3 LOout Gra Rin.
  - nop(11010): no execute steps.
  - halt(11011): no execute steps.
  - jal(10101) and unused codes 11100–11111 behave as nop.
- Transitions:
  - After each class's last step, go to T0.
  - nop goes T2 to T0.
  - halt goes T2 to HALT. HALT holds with all outputs 0 and Run=0 until Clear.
- OP for ALU classes comes from the package opcode-to-ALU table.
- Clear mid-instruction: abort at the edge; no further strobes are issued. A pending st T7 Write is never issued.
- Clear low at every edge (including while in HALT) returns to RST.

Decomposition:
- Package mini_src_ctrl_pkg:
  - opcode constants
  - state encoding
  - ADD_OP
  - opcode-to-class function
  - opcode-to-ALU-op function
- Sub-module ctrl_decode: combinational (state, opcode, CON_FF) to control word. control_unit holds only the state register and next-state logic.

Test Plan:
- Clear low 2 cycles, then high; IR=32'h12200090 (st):
  - T0–T7 strobes exactly as listed; T4 OP=5'b00100; Write only in T7.
  - Next state is T0 with PCout=1.
- IR=32'h18918000 (add R1,R2,R3):
  - T3 Grb Rout Yin; T4 Grc Rout ZLowin with OP=table(add); T5 Gra Rin.
  - Back to T0 at the 7th cycle after T0.
- Branch IR=32'h98000010:
  - CON_FF=1: T6 PCin=1.
  - CON_FF=0: T6 all outputs 0; next T0.
- Clear asserted during st T6: next cycle all outputs 0, Write never pulses, Run=0; restart at T0.
- IR=32'hD8000000 (halt): after T2 Run=0, all outputs 0 for 20+ cycles; Clear restores fetch.
- IR=32'hE0000000 (unused): T2 to T0 directly; no register-file strobe.
